// File: rtl/saa1099_pkg.sv
// Shared types and constants for the SAA1099 write queue.
package saa1099_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int ENTRY_W = 9;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/saa1099_wq_fifo.sv
// Synchronous FIFO of {a0, data} entries. The head is readable combinationally.
module saa1099_wq_fifo
  import saa1099_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [ENTRY_W-1:0]   din,
  output logic [ENTRY_W-1:0]   dout,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_pop_ok;
  logic                  w_push_ok;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk_sys) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/saa1099_write_queue.sv
// Queues CPU writes and replays each as one cs_n/wr_n strobe on the SAA1099 bus at ce pace.
// Defining SAA_QUEUE_DROP_CNT_EN adds a saturating drop_cnt output.
module saa1099_write_queue
  import saa1099_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int STROBE_CE  = 2,
  parameter int GAP_CE     = 1
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 wr_req,
  input  logic                 wr_a0,
  input  logic [7:0]           wr_din,
  input  logic                 ovf_clr,
  output logic                 empty,
  output logic                 full,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 busy,
  output logic                 ovf,
  output logic                 saa_cs_n,
  output logic                 saa_a0,
  output logic                 saa_wr_n,
`ifdef SAA_QUEUE_DROP_CNT_EN
  output logic [7:0]           drop_cnt,
`endif
  output logic [7:0]           saa_din
);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_cs_n, w_cs_n_nxt;
  logic               r_wr_n, w_wr_n_nxt;
  logic               r_a0, w_a0_nxt;
  logic [7:0]         r_din, w_din_nxt;
  logic               r_ovf;
  logic               w_pop;
  logic               w_drop;
  logic               w_empty;
  logic               w_full;
  logic [ENTRY_W-1:0] w_head;
  logic [DEPTH_LOG2:0] w_level;

  saa1099_wq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst     (rst),
    .push    (wr_req),
    .pop     (w_pop),
    .din     ({wr_a0, wr_din}),
    .dout    (w_head),
    .level   (w_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_drop = wr_req && w_full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cs_n_nxt  = r_cs_n;
    w_wr_n_nxt  = r_wr_n;
    w_a0_nxt    = r_a0;
    w_din_nxt   = r_din;
    w_pop       = 1'b0;
    case (r_state)
      // IDLE ignores ce so a queued write starts on the very next clk.
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_a0_nxt    = w_head[8];
          w_din_nxt   = w_head[7:0];
          w_cs_n_nxt  = 1'b0;
          w_wr_n_nxt  = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (ce) begin
          w_wr_n_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (ce) begin
          if (r_cnt == CNT_W'(STROBE_CE - 1)) begin
            w_wr_n_nxt  = 1'b1;
            w_cs_n_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (ce) begin
          if (r_cnt == CNT_W'(GAP_CE - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cs_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_a0    <= 1'b0;
      r_din   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_a0    <= w_a0_nxt;
      r_din   <= w_din_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef SAA_QUEUE_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= ovf_clr ? 8'd1 : ((r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1);
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = w_level;
  assign busy     = (r_state != ST_IDLE) || !w_empty;
  assign ovf      = r_ovf;
  assign saa_cs_n = r_cs_n;
  assign saa_wr_n = r_wr_n;
  assign saa_a0   = r_a0;
  assign saa_din  = r_din;

endmodule

// File: tb/tb_saa1099_write_queue.sv
// Bench for saa1099_write_queue: queue-plus-elapsed-ce-tick model checked every cycle, plus directed literals.
module tb_saa1099_write_queue;

  localparam int DL    = 4;
  localparam int DEPTH = 2 ** DL;
  localparam int S     = 2;
  localparam int G     = 1;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          wr_req = 1'b0;
  logic          wr_a0 = 1'b0;
  logic [7:0]    wr_din = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          empty, full, busy, ovf, saa_cs_n, saa_a0, saa_wr_n;
  logic [DL:0]   level;
  logic [7:0]    saa_din;
`ifdef SAA_QUEUE_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  saa1099_write_queue #(
    .DEPTH_LOG2 (DL),
    .STROBE_CE  (S),
    .GAP_CE     (G)
  ) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .ce       (ce),
    .wr_req   (wr_req),
    .wr_a0    (wr_a0),
    .wr_din   (wr_din),
    .ovf_clr  (ovf_clr),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .busy     (busy),
    .ovf      (ovf),
    .saa_cs_n (saa_cs_n),
    .saa_a0   (saa_a0),
    .saa_wr_n (saa_wr_n),
`ifdef SAA_QUEUE_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .saa_din  (saa_din)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: a queue of pending entries and one in-flight write described by how many
  // ce ticks have elapsed since it was taken: 0 = setup, 1..S = strobe, S+1..S+G = gap.
  logic [8:0] m_q[$];
  logic [8:0] m_cur = 9'h000;
  bit         m_act = 1'b0;
  int         m_t = 0;
  bit         m_ovf = 1'b0;
  int         m_drop = 0;
  bit         m_valid = 1'b0;

  task automatic model_step();
    bit pop_now;
    bit drop;
    m_valid = 1'b1;
    if (rst) begin
      m_q.delete();
      m_act = 1'b0; m_t = 0; m_cur = 9'h000; m_ovf = 1'b0; m_drop = 0;
      return;
    end
    pop_now = !m_act && (m_q.size() != 0);
    if (m_act && ce) begin
      m_t++;
      if (m_t == 1 + S + G) m_act = 1'b0;
    end
    if (pop_now) begin
      m_cur = m_q.pop_front();
      m_act = 1'b1;
      m_t   = 0;
    end
    drop = wr_req && (m_q.size() == DEPTH);
    if (wr_req && !drop) m_q.push_back({wr_a0, wr_din});
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (drop) m_drop = ovf_clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
    else if (ovf_clr) m_drop = 0;
  endtask

  logic [8:0] s_log[$];
  logic       prev_wr_n = 1'b1;

  always @(negedge clk_sys) begin
    if (m_valid) begin
      chk("level", level, m_q.size());
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("busy", busy, m_act || (m_q.size() != 0));
      chk("ovf", ovf, m_ovf);
      chk("cs_n", saa_cs_n, !(m_act && m_t <= S));
      chk("wr_n", saa_wr_n, !(m_act && m_t >= 1 && m_t <= S));
      chk("a0", saa_a0, m_cur[8]);
      chk("din", saa_din, m_cur[7:0]);
`ifdef SAA_QUEUE_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, m_drop);
`endif
      if (prev_wr_n === 1'b1 && saa_wr_n === 1'b0) s_log.push_back({saa_a0, saa_din});
      prev_wr_n = saa_wr_n;
    end
  end

  task automatic cyc(input logic req, input logic a0, input logic [7:0] d, input logic c,
                     input logic clr = 1'b0, input logic r = 1'b0);
    @(negedge clk_sys);
    wr_req = req; wr_a0 = a0; wr_din = d; ce = c; ovf_clr = clr; rst = r;
    @(posedge clk_sys);
    model_step();
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    #1;
    while (busy !== 1'b0 && n < 400) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      #1;
      n++;
    end
    chk(nm, busy, 0);
  endtask

  initial begin
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_wr_n", saa_wr_n, 1);
    chk("rst_cs_n", saa_cs_n, 1);
    chk("rst_busy", busy, 0);

    // Address then data write, ce every third clk.
    s_log.delete();
    cyc(1'b1, 1'b1, 8'h18, 1'b0);
    cyc(1'b1, 1'b0, 8'h85, 1'b0);
    for (int k = 0; k < 60; k++) cyc(1'b0, 1'b0, 8'h00, (k % 3) == 0);
    #1;
    chk("t1_count", s_log.size(), 2);
    chk("t1_first", s_log[0], 9'h118);
    chk("t1_second", s_log[1], 9'h085);
    chk("t1_idle", busy, 0);

    // ce frozen: the idle writer takes entry 0 at once, 16 fill the FIFO, 3 are dropped.
    s_log.delete();
    for (int i = 0; i < 20; i++) cyc(1'b1, i[0], 8'(8'h40 + i), 1'b0);
    #1;
    chk("t2_level", level, 16);
    chk("t2_full", full, 1);
    chk("t2_ovf", ovf, 1);
    drain("t2_drain");
    chk("t2_count", s_log.size(), 17);
    chk("t2_first", s_log[0], 9'h040);
    chk("t2_last", s_log[16], 9'h050);
    chk("t2_empty", empty, 1);

    // Push into a full FIFO on the clk the idle writer pops.
    s_log.delete();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    #1;
    chk("t3_level_pre", level, 16);
    chk("t3_ovf_pre", ovf, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0);
    #1;
    chk("t3_level", level, 16);
    chk("t3_ovf", ovf, 0);
    chk("t3_cs_n", saa_cs_n, 0);
    drain("t3_drain");
    chk("t3_count", s_log.size(), 18);
    chk("t3_last", s_log[17], 9'h1EE);

    // Minimum latency, then reset mid-strobe.
    s_log.delete();
    cyc(1'b1, 1'b0, 8'h33, 1'b1);
    cyc(1'b1, 1'b1, 8'h44, 1'b1);
    #1;
    chk("t4_setup_cs_n", saa_cs_n, 0);
    chk("t4_setup_wr_n", saa_wr_n, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("t4_strobe_wr_n", saa_wr_n, 0);
    chk("t4_strobe_din", saa_din, 8'h33);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    #1;
    chk("t4_rst_wr_n", saa_wr_n, 1);
    chk("t4_rst_cs_n", saa_cs_n, 1);
    chk("t4_rst_level", level, 0);
    chk("t4_rst_din", saa_din, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("t4_count", s_log.size(), 1);

    // ce held low for 50 clks after the first strobe tick.
    cyc(1'b1, 1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("t5_wr_n_held", saa_wr_n, 0);
    chk("t5_din_held", saa_din, 8'h5A);
    chk("t5_a0_held", saa_a0, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    #1;
    chk("t5_wr_n_rise", saa_wr_n, 1);
    chk("t5_cs_n_rise", saa_cs_n, 1);
    drain("t5_drain");

    // Overflow saturation and clear priority.
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    #1;
    chk("t6_ovf", ovf, 1);
`ifdef SAA_QUEUE_DROP_CNT_EN
    chk("t6_drop_sat", drop_cnt, 255);
`endif
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("t6_ovf_clr", ovf, 0);
`ifdef SAA_QUEUE_DROP_CNT_EN
    chk("t6_drop_clr", drop_cnt, 0);
`endif
    cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    #1;
    chk("t6_set_wins", ovf, 1);
`ifdef SAA_QUEUE_DROP_CNT_EN
    chk("t6_drop_one", drop_cnt, 1);
`endif
    drain("t6_drain");
    chk("t6_empty", empty, 1);

    @(negedge clk_sys);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
